clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//   Runtime-programmable clock divider / timebase for the Morse timer path.
//   Derives dot/dash/gap timing from the system clock.
//   Generalises the fixed clock multiplier with:
//   - a wide divisor
//   - glitch-free divisor reload at period boundaries
//   - three modes: square wave, periodic tick, one-shot
//   - count enable and busy/status outputs
//   Fully synchronous: counts rising edges of clk only; no logic on the clock edge itself.
// PARAMETERS
//   WID      16  width of divisor and counter (max divisor 2^WID-1)
//   DEF_DIV  2   divisor loaded on reset; must be >=1 and <2^WID
// PORTS
//   clk      in   1    system clock, all state changes on posedge
//   rst      in   1    reset, synchronous, active-high
//   en       in   1    count enable; low freezes counter and clk_out
//   mode     in   2    00 square, 01 tick, 10 one-shot, 11 reserved (=tick)
//   div_ld   in   1    1-cycle strobe: capture div_in into the pending register
//   div_in   in   WID  new divisor D; 0 is clamped to 1
//   start    in   1    one-shot trigger (mode 10 only)
//   clk_out  out  1    square wave, period 2*D cycles (mode 00), else 0
//   tick     out  1    1-cycle pulse at end of each period / one-shot
//   busy     out  1    one-shot in progress
//   div_cur  out  WID  divisor currently in use
//   cnt      out  WID  current count, 0..div_cur-1
// BEHAVIOUR
//   Reset (rst=1 at posedge)
//     - cnt=0, clk_out=0, tick=0, busy=0
//     - div_cur=DEF_DIV, pending-valid=0
//   Wrap condition W = en & (cnt==div_cur-1) & active
//     - active = 1 in modes 00/01
//     - active = busy in mode 10
//   Counter
//     - if en&active: cnt <= W ? 0 : cnt+1
//     - else cnt holds
//     - In mode 10 with busy=0: cnt is 0
//   Outputs, all registered, updated at the edge where W is true
//     - Mode 00: clk_out toggles; tick pulses.
//       With D=1, clk_out toggles every cycle.
//     - Mode 01: tick pulses for 1 cycle each period (every D enabled cycles).
//     - Mode 10: start & en & ~busy sets busy=1 and cnt=0.
//       At W: busy->0 and tick pulses.
//       start while busy is ignored; start while en=0 is ignored.
//   tick timing and en
//     - tick is high only in the cycle following W.
//     - en=0 forces tick=0 on the next edge.
//   Latency: from the first enabled edge with cnt=0, W occurs on the D-th enabled edge.
//   Divisor reload
//     - div_ld latches clamp(div_in) into pending; sets pending-valid.
//     - Pending is applied to div_cur at the next W, or immediately when idle.
//       Idle = mode 10 & ~busy.
//     - The new period starts at cnt=0.
//     - div_ld in the same cycle as W: the loaded value is used from the following period.
//     - The old value is never cut short.
//     - Repeated div_ld before apply: last value wins.
//   Mode change: when mode differs from the previous cycle, the next edge sets:
//     - cnt=0, clk_out=0, busy=0, tick=0
//     - pending is kept
//   Width: cnt+1 is computed at WID bits.
//     - cnt never exceeds div_cur-1, so no overflow.
//     - div_cur-1 is computed with D>=1 guaranteed by the clamp.
//   rst has priority over all inputs, including mid-period and mid-one-shot.
// TESTING
//   1. rst, mode=00, D=DEF_DIV=2, en=1 -> clk_out toggles at edges 2,4,6 (period 4); tick every 2 cycles.
//   2. mode=01, div_ld div_in=5 mid-period of D=3
//      -> current 3-cycle period completes, then ticks every 5 cycles; div_cur=5 after that wrap.
//   3. mode=10, D=4, start pulse -> busy=1 for 4 cycles; tick once after the 4th edge; busy=0.
//      A second start during busy is ignored.
//   4. mode=01, D=4, en low for 3 cycles at cnt=2 -> cnt holds 2, no tick; resumes and ticks 2 enabled cycles later.
//   5. div_in=0 -> div_cur=1 after apply; mode 00 clk_out toggles every cycle; mode 01 tick every cycle.
//   6. rst asserted mid one-shot at cnt=3 -> next cycle busy=0, cnt=0, tick=0, div_cur=DEF_DIV.

Source files
------------

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
//   Runtime-programmable clock divider / timebase for the Morse timer path.
//   It derives dot/dash/gap timing from the system clock. Every state change
//   happens on the rising edge of i_clk. No logic is ever placed on the clock
//   path itself.
//
//   Modes (i_mode):
//     00  square wave : o_clk_out toggles every D enabled cycles (period 2*D)
//     01  tick        : o_tick pulses once every D enabled cycles
//     10  one-shot    : i_start begins a single D-cycle run, then one tick
//     11  reserved    : behaves exactly like 01
//
//   A new divisor is written with i_div_ld into a pending register. It only
//   reaches the live divisor at a period boundary, or straight away when the
//   block is idle (one-shot mode, not busy). A period that is already running
//   is therefore never shortened or stretched.
//
// Parameters
//   WID      width of divisor and counter (max divisor 2^WID-1)
//   DEF_DIV  divisor loaded on reset (1 .. 2^WID-1)
//
// Ports
//   i_clk      in   1    system clock
//   i_rst      in   1    synchronous active-high reset, highest priority
//   i_en       in   1    count enable; low freezes counter and o_clk_out
//   i_mode     in   2    operating mode, see above
//   i_div_ld   in   1    strobe: capture i_div_in into the pending register
//   i_div_in   in   WID  new divisor; 0 is treated as 1
//   i_start    in   1    one-shot trigger (mode 10 only)
//   o_clk_out  out  1    square wave in mode 00, otherwise 0
//   o_tick     out  1    one-cycle pulse after each period end
//   o_busy     out  1    one-shot in progress
//   o_div_cur  out  WID  divisor currently in use
//   o_cnt      out  WID  current count, 0 .. o_div_cur-1
//
// Handshake: i_div_ld and i_start are single-cycle strobes sampled at the
// rising edge. There is no back-pressure. A start that arrives while the
// block is busy, while i_en is low, or outside mode 10 is dropped.
// -----------------------------------------------------------------------------
module clk_div_prog #(
  parameter int WID     = 16,
  parameter int DEF_DIV = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic [1:0]     i_mode,
  input  logic           i_div_ld,
  input  logic [WID-1:0] i_div_in,
  input  logic           i_start,
  output logic           o_clk_out,
  output logic           o_tick,
  output logic           o_busy,
  output logic [WID-1:0] o_div_cur,
  output logic [WID-1:0] o_cnt
);

  localparam logic [1:0]     MODE_SQUARE  = 2'b00;
  localparam logic [1:0]     MODE_ONESHOT = 2'b10;
  localparam logic [WID-1:0] ONE          = WID'(1);
  localparam logic [WID-1:0] DEF          = WID'(DEF_DIV);

  // Registered state
  logic [WID-1:0] r_cnt;
  logic [WID-1:0] r_div;
  logic [WID-1:0] r_pend;
  logic           r_pend_v;
  logic           r_clk;
  logic           r_tick;
  logic           r_busy;
  logic [1:0]     r_mode_q;

  // Combinational decode
  logic           w_mode_chg;
  logic           w_oneshot;
  logic           w_square;
  logic           w_active;
  logic           w_last;
  logic           w_wrap;
  logic           w_idle;
  logic           w_apply;
  logic           w_fire;
  logic [WID-1:0] w_din_clamped;
  logic [WID-1:0] w_cnt_inc;

  always_comb begin
    w_mode_chg    = (i_mode != r_mode_q);
    w_oneshot     = (i_mode == MODE_ONESHOT);
    w_square      = (i_mode == MODE_SQUARE);
    // Periodic modes always run; one-shot runs only while a shot is active.
    w_active      = w_oneshot ? r_busy : 1'b1;
    // r_div is never 0 because every load is clamped, so r_div-1 cannot wrap.
    w_last        = (r_cnt == (r_div - ONE));
    // A mode change restarts everything, so no period may end in that cycle.
    w_wrap        = i_en & w_active & w_last & ~w_mode_chg;
    w_idle        = w_oneshot & ~r_busy;
    // The pending value is sampled before this cycle's load lands. A load in
    // the same cycle as a wrap is therefore used one period later.
    w_apply       = r_pend_v & (w_wrap | w_idle);
    w_fire        = w_oneshot & i_start & i_en & ~r_busy & ~w_mode_chg;
    w_din_clamped = (i_div_in == '0) ? ONE : i_div_in;
    // r_cnt stays below r_div, so the increment cannot overflow WID bits.
    w_cnt_inc     = r_cnt + ONE;
  end

  // Divisor and pending-divisor registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div    <= DEF;
      r_pend   <= DEF;
      r_pend_v <= 1'b0;
    end else begin
      if (w_apply) begin
        r_div <= r_pend;
      end
      // Repeated loads before an apply simply overwrite: the last value wins.
      if (i_div_ld) begin
        r_pend   <= w_din_clamped;
        r_pend_v <= 1'b1;
      end else if (w_apply) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  // The previous mode is tracked even during reset. Leaving reset in any
  // mode therefore does not look like a mode change.
  always_ff @(posedge i_clk) begin
    r_mode_q <= i_mode;
  end

  // Counter, one-shot flag and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
      r_busy <= 1'b0;
    end else if (w_mode_chg) begin
      r_cnt  <= '0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      // The tick follows the wrap. w_wrap already contains i_en, so en=0
      // forces the tick low on the next edge.
      r_tick <= w_wrap;

      if (w_wrap || w_fire) begin
        r_cnt <= '0;
      end else if (i_en && w_active) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_fire) begin
        r_busy <= 1'b1;
      end else if (w_wrap && w_oneshot) begin
        r_busy <= 1'b0;
      end

      if (!w_square) begin
        r_clk <= 1'b0;
      end else if (w_wrap) begin
        r_clk <= ~r_clk;
      end
    end
  end

  assign o_clk_out = r_clk;
  assign o_tick    = r_tick;
  assign o_busy    = r_busy;
  assign o_div_cur = r_div;
  assign o_cnt     = r_cnt;

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
//   Self-checking bench for clk_div_prog. A behavioural model describes the
//   timebase as periods and elapsed cycles:
//     - period count
//     - elapsed cycles in the current period
//     - queue of requested divisors
//   After every clock the model is compared against the DUT outputs.
//   Directed scenarios also check the headline timing with fixed constants.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;
  localparam int W   = 16;
  localparam int DEF = 2;

  // Clock / reset and DUT signals
  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_en = 1'b0;
  logic [1:0]   i_mode = 2'b00;
  logic         i_div_ld = 1'b0;
  logic [W-1:0] i_div_in = '0;
  logic         i_start = 1'b0;
  logic         o_clk_out;
  logic         o_tick;
  logic         o_busy;
  logic [W-1:0] o_div_cur;
  logic [W-1:0] o_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 i_clk = ~i_clk;

  clk_div_prog #(.WID(W), .DEF_DIV(DEF)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mode(i_mode),
    .i_div_ld(i_div_ld), .i_div_in(i_div_in), .i_start(i_start),
    .o_clk_out(o_clk_out), .o_tick(o_tick), .o_busy(o_busy),
    .o_div_cur(o_div_cur), .o_cnt(o_cnt)
  );

  // Reference model
  //   m_div    divisor in use
  //   m_phase  enabled cycles elapsed in the current period
  //   m_nper   completed periods since the last restart (square level = parity)
  //   pend_q   divisor requests not yet in use; the newest one wins
  int           m_div, m_phase, m_nper;
  bit           m_clk, m_tick, m_busy;
  logic [1:0]   m_prev;
  logic [W-1:0] pend_q[$];

  task automatic model_step();
    bit oneshot, running, chg, period_end;
    if (i_rst) begin
      m_div = DEF; m_phase = 0; m_nper = 0;
      m_clk = 0; m_tick = 0; m_busy = 0;
      pend_q.delete();
      m_prev = i_mode;
      return;
    end
    oneshot    = (i_mode == 2'b10);
    running    = !oneshot || m_busy;
    chg        = (i_mode != m_prev);
    m_prev     = i_mode;
    period_end = !chg && i_en && running && (m_phase + 1 == m_div);
    if (pend_q.size() > 0 && (period_end || (oneshot && !m_busy))) begin
      m_div = int'(pend_q[$]);
      pend_q.delete();
    end
    if (i_div_ld) pend_q.push_back((i_div_in == 0) ? W'(1) : i_div_in);
    if (chg) begin
      m_phase = 0; m_nper = 0; m_busy = 0; m_tick = 0; m_clk = 0;
      return;
    end
    m_tick = period_end;
    if (period_end) begin
      m_phase = 0;
      m_nper++;
      if (oneshot) m_busy = 0;
    end else if (oneshot && !m_busy) begin
      if (i_start && i_en) m_busy = 1;
      m_phase = 0;
    end else if (i_en) begin
      m_phase++;
    end
    m_clk = (i_mode == 2'b00) ? (m_nper % 2 == 1) : 1'b0;
  endtask

  function automatic logic [2*W+2:0] exp_vec();
    return {m_clk, m_tick, m_busy, W'(m_div), W'(m_phase)};
  endfunction

  function automatic logic [2*W+2:0] obs_vec();
    return {o_clk_out, o_tick, o_busy, o_div_cur, o_cnt};
  endfunction

  // Driver: one clock; the model sees the same inputs; sample 1ns later.
  task automatic step();
    @(posedge i_clk);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [1:0] mode);
    i_rst = 1; i_mode = mode; i_en = 1; i_div_ld = 0; i_start = 0;
    step();
    i_rst = 0;
  endtask

  task automatic test_reset();
    // Reset must win over every other input.
    i_rst = 1; i_en = 1; i_mode = 2'b00; i_start = 1; i_div_ld = 1; i_div_in = 9;
    step();
    i_rst = 0; i_start = 0; i_div_ld = 0;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_model got=%h want=%h", obs_vec(), exp_vec());
    end
    total++;
    if ({o_clk_out, o_tick, o_busy, o_cnt, o_div_cur} !== {3'b000, W'(0), W'(DEF)}) begin
      bad++; $display("FAIL reset_values got clk=%b tick=%b busy=%b cnt=%0d div=%0d want 0 0 0 0 %0d",
                      o_clk_out, o_tick, o_busy, o_cnt, o_div_cur, DEF);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_after cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_square();
    do_reset(2'b00);
    for (int e = 1; e <= 8; e++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL square_model edge=%0d got=%h want=%h", e, obs_vec(), exp_vec());
      end
      total++;
      if ({o_clk_out, o_tick} !== {((e / 2) % 2 == 1), (e % 2 == 0)}) begin
        bad++; $display("FAIL square_wave edge=%0d got clk=%b tick=%b want clk=%b tick=%b",
                        e, o_clk_out, o_tick, ((e / 2) % 2 == 1), (e % 2 == 0));
      end
    end
  endtask

  task automatic test_reload();
    int tq[$];
    int guard;
    do_reset(2'b01);
    i_div_ld = 1; i_div_in = 3; step(); i_div_ld = 0;
    guard = 0;
    while (!(o_tick && o_div_cur == 3) && guard < 20) begin step(); guard++; end
    total++;
    if (guard >= 20) begin bad++; $display("FAIL reload_first got=timeout want=div 3 tick"); end
    step();                                   // cnt=1, mid-period of D=3
    i_div_ld = 1; i_div_in = 5;
    for (int r = 2; r <= 16; r++) begin
      step();
      i_div_ld = 0;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reload_model rel=%0d got=%h want=%h", r, obs_vec(), exp_vec());
      end
      if (o_tick) tq.push_back(r);
    end
    total++;
    if (tq.size() != 3 || tq[0] != 3 || tq[1] != 8 || tq[2] != 13) begin
      bad++; $display("FAIL reload_ticks got n=%0d first=%0d want ticks at 3,8,13",
                      tq.size(), (tq.size() > 0) ? tq[0] : -1);
    end
    total++;
    if (o_div_cur !== W'(5)) begin
      bad++; $display("FAIL reload_div got=%0d want=5", o_div_cur);
    end
  endtask

  task automatic test_oneshot();
    int nbusy, ntick;
    do_reset(2'b10);
    i_div_ld = 1; i_div_in = 4; step(); i_div_ld = 0;
    step();                                   // idle: pending applied now
    total++;
    if (o_div_cur !== W'(4)) begin bad++; $display("FAIL oneshot_div got=%0d want=4", o_div_cur); end
    i_start = 1; step(); i_start = 0;
    nbusy = o_busy ? 1 : 0;
    ntick = 0;
    for (int i = 0; i < 8; i++) begin
      i_start = (i == 1);                     // a restart while busy is dropped
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL oneshot_model i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      if (o_busy) nbusy++;
      if (o_tick) ntick++;
    end
    i_start = 0;
    total++;
    if (nbusy != 4 || ntick != 1) begin
      bad++; $display("FAIL oneshot_count got busy=%0d ticks=%0d want busy=4 ticks=1", nbusy, ntick);
    end
  endtask

  task automatic test_enable();
    int guard;
    do_reset(2'b01);
    i_div_ld = 1; i_div_in = 4; step(); i_div_ld = 0;
    guard = 0;
    while (!(o_tick && o_div_cur == 4) && guard < 20) begin step(); guard++; end
    total++;
    if (guard >= 20) begin bad++; $display("FAIL enable_sync got=timeout want=div 4 tick"); end
    step(); step();
    i_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({o_cnt, o_tick} !== {W'(2), 1'b0}) begin
        bad++; $display("FAIL enable_hold i=%0d got cnt=%0d tick=%b want cnt=2 tick=0", i, o_cnt, o_tick);
      end
    end
    i_en = 1;
    step();
    step();
    total++;
    if ({o_cnt, o_tick} !== {W'(0), 1'b1}) begin
      bad++; $display("FAIL enable_resume got cnt=%0d tick=%b want cnt=0 tick=1", o_cnt, o_tick);
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL enable_model got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_div_zero();
    int guard;
    logic prev_clk;
    do_reset(2'b00);
    i_div_ld = 1; i_div_in = 0; step(); i_div_ld = 0;
    guard = 0;
    while (o_div_cur != 1 && guard < 20) begin step(); guard++; end
    total++;
    if (guard >= 20) begin bad++; $display("FAIL divzero_apply got div=%0d want=1", o_div_cur); end
    for (int i = 0; i < 5; i++) begin
      prev_clk = o_clk_out;
      step();
      total++;
      if ({o_clk_out, o_tick} !== {~prev_clk, 1'b1}) begin
        bad++; $display("FAIL divzero_square i=%0d got clk=%b tick=%b want clk=%b tick=1",
                        i, o_clk_out, o_tick, ~prev_clk);
      end
    end
    i_mode = 2'b01;
    step();                                   // mode change restarts the count
    total++;
    if ({o_clk_out, o_tick, o_cnt} !== {2'b00, W'(0)}) begin
      bad++; $display("FAIL divzero_modechg got clk=%b tick=%b cnt=%0d want 0 0 0", o_clk_out, o_tick, o_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (o_tick !== 1'b1 || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL divzero_tick i=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_oneshot();
    int guard;
    do_reset(2'b10);
    i_div_ld = 1; i_div_in = 6; step(); i_div_ld = 0;
    step();
    i_start = 1; step(); i_start = 0;
    guard = 0;
    while (o_cnt != 3 && guard < 20) begin step(); guard++; end
    total++;
    if (guard >= 20 || !o_busy) begin
      bad++; $display("FAIL rstmid_reach got cnt=%0d busy=%b want cnt=3 busy=1", o_cnt, o_busy);
    end
    i_rst = 1; step(); i_rst = 0;
    total++;
    if ({o_busy, o_cnt, o_tick, o_div_cur} !== {1'b0, W'(0), 1'b0, W'(DEF)}) begin
      bad++; $display("FAIL rstmid_state got busy=%b cnt=%0d tick=%b div=%0d want 0 0 0 %0d",
                      o_busy, o_cnt, o_tick, o_div_cur, DEF);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      i_rst    = ($urandom_range(0, 299) == 0);
      i_en     = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 39) == 0) i_mode = 2'($urandom_range(0, 3));
      i_div_ld = ($urandom_range(0, 14) == 0);
      i_div_in = W'($urandom_range(0, 7));
      i_start  = ($urandom_range(0, 5) == 0);
      step();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
    end
    i_rst = 0; i_div_ld = 0; i_start = 0;
  endtask

  initial begin
    test_reset();
    test_square();
    test_reload();
    test_oneshot();
    test_enable();
    test_div_zero();
    test_reset_mid_oneshot();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
